// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Sequential AES MixColumns stage between ShiftRows and AddRoundKey. The block
// holds one 128-bit state and processes it column by column through NCOL
// combinational mix_bytes units. This uses fewer gates than four parallel
// units. A bypass flag, sampled with the state, skips MixColumns for the
// final AES round.
//
// Byte layout: byte k is state[127-8k -: 8]. Column c is bytes 4c..4c+3, with
// row 0 first.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    upstream block available
//   in_ready   out  1    block accepts input this cycle (IDLE only)
//   in_state   in   128  state from ShiftRows
//   in_bypass  in   1    pass state through unchanged (final round)
//   out_valid  out  1    result available
//   out_ready  in   1    downstream accepts result
//   out_state  out  128  MixColumns result or bypassed state
//
// Parameter
//   NCOL       number of mix_bytes instances (columns per cycle): 1, 2 or 4
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mix_bytes
//
// Combinational MixColumns on one column over GF(2^8) mod x^8+x^4+x^3+x+1.
//   i0..i3  in   8 each  column bytes, rows 0..3
//   o0..o3  out  8 each  mixed column bytes, rows 0..3
// -----------------------------------------------------------------------------
module mix_bytes (
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    input  logic [7:0] i2,
    input  logic [7:0] i3,
    output logic [7:0] o0,
    output logic [7:0] o1,
    output logic [7:0] o2,
    output logic [7:0] o3
);

    // Multiply by x (i.e. {02}) with reduction by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each row is {02}*a ^ {03}*b ^ a' ^ b'. Here {03}*b is xtime(b) ^ b.
    assign o0 = xtime(i0) ^ xtime(i1) ^ i1 ^ i2 ^ i3;
    assign o1 = i0 ^ xtime(i1) ^ xtime(i2) ^ i2 ^ i3;
    assign o2 = i0 ^ i1 ^ xtime(i2) ^ xtime(i3) ^ i3;
    assign o3 = xtime(i0) ^ i0 ^ i1 ^ i2 ^ xtime(i3);

endmodule

module mix_columns_iter #(
    parameter int NCOL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (!(NCOL == 1 || NCOL == 2 || NCOL == 4)) begin : g_bad_ncol
            $error("mix_columns_iter: NCOL must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter is 2 bits wide, so NCOL=4 gives a step of 0. That is
    // correct, because one BUSY cycle covers all columns from column 0.
    localparam logic [1:0] COL_STEP = 2'(NCOL);
    localparam logic [1:0] LAST_COL = 2'(4 - NCOL);

    state_t         state_q;
    logic [1:0]     col_q;
    logic [127:0]   work_q;
    logic           out_valid_q;
    logic [127:0]   work_d;

    // Column views of the working register, column 0 first.
    logic [31:0]    cols    [4];
    logic [31:0]    cols_d  [4];
    logic [1:0]     idx     [NCOL];
    logic [31:0]    col_out [NCOL];

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign cols[c] = work_q[127 - 32*c -: 32];
    end

    // Unit j handles column col_q + j during this BUSY cycle.
    for (genvar j = 0; j < NCOL; j++) begin : g_unit
        logic [31:0] col_in;

        assign idx[j]  = col_q + 2'(j);
        assign col_in  = cols[idx[j]];

        mix_bytes u_mix_bytes (
            .i0 (col_in[31:24]),
            .i1 (col_in[23:16]),
            .i2 (col_in[15:8]),
            .i3 (col_in[7:0]),
            .o0 (col_out[j][31:24]),
            .o1 (col_out[j][23:16]),
            .o2 (col_out[j][15:8]),
            .o3 (col_out[j][7:0])
        );
    end

    // Working register with the current column group replaced in place.
    always_comb begin
        // NOTE: assign every element before the per-unit overrides. Any path
        // that leaves an element unassigned would infer a latch.
        for (int c = 0; c < 4; c++) begin
            cols_d[c] = cols[c];
        end
        for (int j = 0; j < NCOL; j++) begin
            cols_d[idx[j]] = col_out[j];
        end
        work_d = {cols_d[0], cols_d[1], cols_d[2], cols_d[3]};
    end

    // Control FSM, column counter and working register.
    // NOTE: all state in this block uses non-blocking assignments. Every
    // register then updates from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            // NOTE: the working register is a plain flop vector, not a RAM.
            // Resetting it is legal and keeps out_state at a known zero.
            work_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_state;
                        col_q  <= 2'd0;
                        if (in_bypass) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    // This wraps to 0 on the last step, ready for the next block.
                    col_q  <= col_q + COL_STEP;
                    if (col_q == LAST_COL) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

    localparam int NSTREAM = 100;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply by shift-and-add with reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // MixColumns as a circulant matrix product. Row r uses coefficient
    // {02,03,01,01}[(k-r) mod 4] on byte k.
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
                r[127 - 8*(4*c + row) -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_blk
        localparam int NC = 1 << g;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [127:0] in_state;
        logic         in_bypass;
        logic         out_valid;
        logic         out_ready;
        logic [127:0] out_state;
        bit           done = 1'b0;
        logic [127:0] q [$];

        mix_columns_iter #(.NCOL(NC)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_state  (in_state),
            .in_bypass (in_bypass),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_state (out_state)
        );

        // Offer one block, then return its result and its latency in edges
        // counted from the accept edge.
        task automatic run_block(input logic [127:0] s, input logic byp,
                                 output logic [127:0] res, output int lat);
            int n;
            @(negedge clk);
            in_valid  = 1'b1;
            in_state  = s;
            in_bypass = byp;
            out_ready = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) check($sformatf("n%0d_accept_timeout", NC), in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            in_valid  = 1'b0;
            in_state  = rand128();
            in_bypass = ~byp;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            lat = out_valid ? n + 1 : -1;
            res = out_state;
            @(posedge clk);
        endtask

        initial begin
            vec_t         vecs [4];
            logic [127:0] res;
            logic [127:0] st_a;
            logic [127:0] st_b;
            logic [127:0] e;
            int           lat;
            int           n;
            int           sent;
            int           got;
            int           gap;
            bit           drop;

            vecs[0] = '{128'hdb135345_00000000_00000000_00000000, 1'b0,
                        128'h8e4da1bc_00000000_00000000_00000000};
            vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                        128'h046681e5e0cb199a48f8d37a2806264c};
            vecs[2] = '{128'h01010101c6c6c6c600000000d4d4d4d5, 1'b0,
                        128'h01010101c6c6c6c600000000d5d5d7d6};
            vecs[3] = '{128'h01010101c6c6c6c600000000d4d4d4d5, 1'b1,
                        128'h01010101c6c6c6c600000000d4d4d4d5};

            // Reset state.
            rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("n%0d_rst_out_valid", NC), out_valid, 0);
            check($sformatf("n%0d_rst_out_state", NC), out_state, 0);
            check($sformatf("n%0d_rst_in_ready", NC), in_ready, 1);
            rst_n = 1'b1;

            // Directed vectors with latency.
            for (int i = 0; i < 4; i++) begin
                run_block(vecs[i].st, vecs[i].byp, res, lat);
                check($sformatf("n%0d_vec%0d_state", NC, i), res, vecs[i].exp);
                check($sformatf("n%0d_vec%0d_latency", NC, i), lat, vecs[i].byp ? 1 : 4 / NC + 1);
            end

            // Back-pressure: hold DONE for 10 cycles while a second block waits.
            st_a = rand128();
            st_b = rand128();
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_state = st_a; in_bypass = 1'b0;
            @(posedge clk);
            @(negedge clk);
            in_state = st_b;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < 10; i++) begin
                check($sformatf("n%0d_bp_valid_c%0d", NC, i), out_valid, 1);
                check($sformatf("n%0d_bp_state_c%0d", NC, i), out_state, mix_ref(st_a));
                check($sformatf("n%0d_bp_in_ready_c%0d", NC, i), in_ready, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("n%0d_bp_release_valid", NC), out_valid, 0);
            check($sformatf("n%0d_bp_release_in_ready", NC), in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("n%0d_bp_second_state", NC), out_state, mix_ref(st_b));
            @(posedge clk);

            // Reset two cycles after accept aborts the block.
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_state = rand128(); in_bypass = 1'b0;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check($sformatf("n%0d_abort_out_valid", NC), out_valid, 0);
            check($sformatf("n%0d_abort_out_state", NC), out_state, 0);
            check($sformatf("n%0d_abort_in_ready", NC), in_ready, 1);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check($sformatf("n%0d_release_in_ready", NC), in_ready, 1);
            run_block(vecs[1].st, 1'b0, res, lat);
            check($sformatf("n%0d_after_abort_state", NC), res, vecs[1].exp);

            // Random stream with gaps on both sides.
            sent = 0; got = 0; drop = 1'b0; gap = $urandom_range(0, 2);
            @(negedge clk);
            in_valid = 1'b0;
            for (int cyc = 0; cyc < 20000 && got < NSTREAM; cyc++) begin
                @(negedge clk);
                if (drop) begin
                    in_valid  = 1'b0;
                    in_state  = rand128();
                    in_bypass = 1'($urandom_range(0, 1));
                    gap       = $urandom_range(0, 3);
                    drop      = 1'b0;
                end
                if (!in_valid && sent < NSTREAM) begin
                    if (gap > 0) gap--;
                    else begin
                        in_valid  = 1'b1;
                        in_state  = rand128();
                        in_bypass = 1'($urandom_range(0, 1));
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(in_bypass ? in_state : mix_ref(in_state));
                    sent++;
                    drop = 1'b1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) check($sformatf("n%0d_stream_extra", NC), out_valid, 0);
                    else begin
                        e = q.pop_front();
                        check($sformatf("n%0d_stream_data", NC), out_state, e);
                    end
                    got++;
                end
            end
            in_valid = 1'b0;
            check($sformatf("n%0d_stream_count", NC), got, NSTREAM);
            check($sformatf("n%0d_stream_leftover", NC), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 100000 && !all_done; t++) begin
            #10;
            all_done = g_blk[0].done && g_blk[1].done && g_blk[2].done;
        end
        if (!all_done) check("tb_timeout", all_done, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
